// File: rtl/core_pkg.sv
// Shared types and constants for the ARM front-end fetch path.
package core_pkg;

    localparam int unsigned PC_W       = 8;
    localparam int unsigned IMEM_DEPTH = 128;
    localparam int unsigned BUBBLE_W   = 2;

    localparam logic [PC_W-1:0] RESET_PC  = 8'hFF;
    localparam logic [PC_W-1:0] LAST_ADDR = PC_W'(IMEM_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_FETCH,
        ST_BUBBLE,
        ST_HALTED
    } fetch_state_e;

    typedef enum logic [1:0] {
        SEL_HOLD,
        SEL_INCR,
        SEL_BRANCH,
        SEL_BOOT
    } pc_sel_e;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC mux (hold / wrapped increment / branch target / boot) and branch-target range check.
module pc_next_sel
    import core_pkg::*;
(
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] branch_target,
    input  pc_sel_e         sel,
    output logic [PC_W-1:0] pc_next,
    output logic            target_err
);

    logic [PC_W-1:0] pc_incr;

    // Sequential fetch wraps at the top of instruction memory, not at 2^PC_W.
    assign pc_incr    = (pc >= LAST_ADDR) ? '0 : pc + 1'b1;
    assign target_err = (branch_target >= PC_W'(IMEM_DEPTH));

    always_comb begin
        unique case (sel)
            SEL_INCR:   pc_next = pc_incr;
            SEL_BRANCH: pc_next = branch_target;
            SEL_BOOT:   pc_next = RESET_PC + 1'b1;
            default:    pc_next = pc;
        endcase
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program-counter FSM and instruction-memory fetch handshake for the core front end.
module pc_fetch_sequencer
    import core_pkg::*;
#(
    parameter int unsigned BUBBLE_CYCLES = 1
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            halt,
    input  logic            imem_ack,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    output logic [PC_W-1:0] pc_current,
    output logic            instr_valid,
    output logic            flush,
    output logic            addr_err,
    output logic            halted
);

    localparam logic [BUBBLE_W-1:0] BUBBLE_LOAD = BUBBLE_W'(BUBBLE_CYCLES);

    fetch_state_e        state, state_next;
    logic [BUBBLE_W-1:0] bubble_cnt, bubble_next;
    logic [PC_W-1:0]     pc_next;
    pc_sel_e             sel;
    logic                target_err;
    logic                addr_err_set;

    pc_next_sel u_pc_next_sel (
        .pc            (pc_current),
        .branch_target (branch_target),
        .sel           (sel),
        .pc_next       (pc_next),
        .target_err    (target_err)
    );

    assign imem_addr = pc_current;
    assign halted    = (state == ST_HALTED);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_next   = state;
        bubble_next  = bubble_cnt;
        sel          = SEL_HOLD;
        addr_err_set = 1'b0;
        imem_req     = 1'b0;
        instr_valid  = 1'b0;
        flush        = 1'b0;

        unique case (state)
            ST_BOOT: begin
                sel        = SEL_BOOT;
                state_next = ST_FETCH;
            end
            ST_FETCH, ST_BUBBLE: begin
                imem_req = (state == ST_FETCH) && !stall;
                // Branch beats halt beats stall beats ack, in both fetch and bubble.
                if (branch_taken) begin
                    if (target_err) begin
                        addr_err_set = 1'b1;
                        state_next   = ST_HALTED;
                    end else begin
                        sel         = SEL_BRANCH;
                        flush       = 1'b1;
                        bubble_next = BUBBLE_LOAD;
                        state_next  = ST_BUBBLE;
                    end
                end else if (halt) begin
                    state_next = ST_HALTED;
                end else if (state == ST_FETCH) begin
                    if (!stall && imem_ack) begin
                        instr_valid = 1'b1;
                        sel         = SEL_INCR;
                    end
                end else begin
                    bubble_next = bubble_cnt - 1'b1;
                    if (bubble_cnt <= 1) begin
                        state_next = ST_FETCH;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (!rst) begin
            state      <= ST_BOOT;
            pc_current <= RESET_PC;
            bubble_cnt <= '0;
            addr_err   <= 1'b0;
        end else begin
            state      <= state_next;
            pc_current <= pc_next;
            bubble_cnt <= bubble_next;
            addr_err   <= addr_err | addr_err_set;
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed self-checking bench for pc_fetch_sequencer.
module tb_pc_fetch_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       stall;
    logic       branch_taken;
    logic [7:0] branch_target;
    logic       halt;
    logic       imem_ack;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic [7:0] pc_current;
    logic       instr_valid;
    logic       flush;
    logic       addr_err;
    logic       halted;

    int checks   = 0;
    int failures = 0;

    pc_fetch_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halt          (halt),
        .imem_ack      (imem_ack),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .pc_current    (pc_current),
        .instr_valid   (instr_valid),
        .flush         (flush),
        .addr_err      (addr_err),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 8'h00;
        halt          = 1'b0;
        imem_ack      = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc"},    32'(pc_current),  32'hFF);
        check({tag, "_req"},   32'(imem_req),    32'h0);
        check({tag, "_valid"}, 32'(instr_valid), 32'h0);
        check({tag, "_flush"}, 32'(flush),       32'h0);
        check({tag, "_aerr"},  32'(addr_err),    32'h0);
        check({tag, "_halt"},  32'(halted),      32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        tick();
        tick();
    endtask

    initial begin
        idle_inputs();
        #2;
        do_reset();
        check_reset_outputs("reset");

        // Test 1: BOOT then back-to-back fetches
        rst      = 1'b1;
        imem_ack = 1'b1;
        #1;
        check("boot_req", 32'(imem_req), 32'h0);
        tick();
        for (int i = 0; i < 6; i++) begin
            check($sformatf("seq_pc%0d", i),    32'(pc_current),  32'(i));
            check($sformatf("seq_addr%0d", i),  32'(imem_addr),   32'(i));
            check($sformatf("seq_valid%0d", i), 32'(instr_valid), 32'h1);
            check($sformatf("seq_req%0d", i),   32'(imem_req),    32'h1);
            if (i < 5) tick();
        end

        // Test 3: branch at pc 0x05 with ack in the same cycle
        branch_taken  = 1'b1;
        branch_target = 8'h40;
        #1;
        check("br_flush", 32'(flush),       32'h1);
        check("br_valid", 32'(instr_valid), 32'h0);
        tick();
        branch_taken = 1'b0;
        #1;
        check("bub_pc",    32'(pc_current),  32'h40);
        check("bub_req",   32'(imem_req),    32'h0);
        check("bub_valid", 32'(instr_valid), 32'h0);
        check("bub_flush", 32'(flush),       32'h0);
        tick();
        check("tgt_pc",    32'(pc_current),  32'h40);
        check("tgt_req",   32'(imem_req),    32'h1);
        check("tgt_valid", 32'(instr_valid), 32'h1);
        tick();
        check("tgt_next", 32'(pc_current), 32'h41);

        // Test 4: three stalled cycles with ack held high
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("stall_pc%0d", i),    32'(pc_current),  32'h41);
            check($sformatf("stall_req%0d", i),   32'(imem_req),    32'h0);
            check($sformatf("stall_valid%0d", i), 32'(instr_valid), 32'h0);
            tick();
        end
        stall = 1'b0;
        #1;
        check("unstall_pc",    32'(pc_current),  32'h41);
        check("unstall_valid", 32'(instr_valid), 32'h1);
        tick();
        check("unstall_next", 32'(pc_current), 32'h42);

        // Ack low: hold PC with the request still up
        imem_ack = 1'b0;
        #1;
        check("noack_req",   32'(imem_req),    32'h1);
        check("noack_valid", 32'(instr_valid), 32'h0);
        tick();
        check("noack_pc", 32'(pc_current), 32'h42);

        // Test 2: wrap from 0x7F to 0x00
        branch_taken  = 1'b1;
        branch_target = 8'h7F;
        tick();
        branch_taken = 1'b0;
        tick();
        imem_ack = 1'b1;
        #1;
        check("wrap_pc",    32'(pc_current),  32'h7F);
        check("wrap_valid", 32'(instr_valid), 32'h1);
        tick();
        check("wrap_next", 32'(pc_current), 32'h00);
        check("wrap_aerr", 32'(addr_err),   32'h0);

        // Branch during bubble reloads the PC and restarts the bubble
        branch_taken  = 1'b1;
        branch_target = 8'h10;
        tick();
        branch_target = 8'h20;
        #1;
        check("rebr_flush", 32'(flush),    32'h1);
        check("rebr_req",   32'(imem_req), 32'h0);
        tick();
        branch_taken = 1'b0;
        #1;
        check("rebr_pc",  32'(pc_current), 32'h20);
        check("rebr_req2", 32'(imem_req),  32'h0);
        tick();
        check("rebr_fetch", 32'(imem_req), 32'h1);

        // Test 6b: simultaneous halt and branch, branch wins
        branch_taken  = 1'b1;
        branch_target = 8'h30;
        halt          = 1'b1;
        #1;
        check("bh_flush", 32'(flush), 32'h1);
        tick();
        branch_taken = 1'b0;
        halt         = 1'b0;
        #1;
        check("bh_pc",   32'(pc_current), 32'h30);
        check("bh_halt", 32'(halted),     32'h0);
        tick();
        check("bh_req", 32'(imem_req), 32'h1);

        // Plain halt, then everything but reset is ignored
        halt = 1'b1;
        #1;
        check("halt_valid", 32'(instr_valid), 32'h0);
        tick();
        halt          = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 8'h10;
        #1;
        check("halted_flag",  32'(halted),   32'h1);
        check("halted_req",   32'(imem_req), 32'h0);
        check("halted_flush", 32'(flush),    32'h0);
        tick();
        check("halted_pc", 32'(pc_current), 32'h30);

        // Test 6a: reset asserted mid-bubble
        do_reset();
        rst      = 1'b1;
        imem_ack = 1'b1;
        tick();
        branch_taken  = 1'b1;
        branch_target = 8'h50;
        tick();
        branch_taken = 1'b0;
        rst          = 1'b0;
        tick();
        check_reset_outputs("rst_bub");
        rst = 1'b1;
        #1;
        check("rst_boot_req", 32'(imem_req), 32'h0);
        tick();
        check("rst_boot_pc", 32'(pc_current), 32'h00);

        // Test 5: out-of-range branch target
        branch_taken  = 1'b1;
        branch_target = 8'h90;
        tick();
        branch_taken = 1'b0;
        #1;
        check("aerr_flag", 32'(addr_err),   32'h1);
        check("aerr_halt", 32'(halted),     32'h1);
        check("aerr_req",  32'(imem_req),   32'h0);
        check("aerr_pc",   32'(pc_current), 32'h00);
        tick();
        tick();
        check("aerr_sticky", 32'(addr_err), 32'h1);
        do_reset();
        check_reset_outputs("aerr_clr");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
Controls the 8-bit program counter and the instruction-memory fetch handshake for the ARM core front end.
- Decides each cycle whether the PC advances by one, redirects to a taken-branch target, holds for a stall, or stops on halt.
- Drives the request to the 128-entry instruction memory.
- Flags the fetched word as valid to decode.
- Issues a flush pulse on redirect.

Parameters:
PC_W, 8, program counter width
IMEM_DEPTH, 128, instruction memory depth in words; legal addresses 0..IMEM_DEPTH-1
RESET_PC, 8'hFF, PC value held during reset; the first fetch is from RESET_PC+1 = 0x00
BUBBLE_CYCLES, 1, dead cycles inserted after a branch redirect (legal range 1..3)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-low reset
stall  in  1  decode/execute back-pressure; hold the PC, no new request
branch_taken  in  1  resolved taken branch (branch, in==2'b11 and cond_satisfy already combined upstream)
branch_target  in  PC_W  absolute redirect address
halt  in  1  stop fetching; only reset leaves HALTED
imem_ack  in  1  instruction memory has returned the word for imem_addr this cycle
imem_req  out  1  fetch request
imem_addr  out  PC_W  fetch address; always equals pc_current
pc_current  out  PC_W  registered PC
instr_valid  out  1  one-cycle pulse: the word at pc_current is accepted
flush  out  1  one-cycle pulse on redirect; decode discards its in-flight instruction
addr_err  out  1  sticky: branch target >= IMEM_DEPTH
halted  out  1  high while in HALTED

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-low; it is sampled only on the rising edge of clk.
- Reset values (rst==0 at an edge):
  - state = BOOT, pc_current = RESET_PC.
  - imem_req, instr_valid, flush, addr_err and halted are all 0.
  - Reset asserted mid-fetch or mid-bubble abandons the operation. No instr_valid or flush pulse is produced.
- States: BOOT, FETCH, BUBBLE, HALTED.
- BOOT:
  - One cycle after reset releases.
  - On the next edge: pc_current <= (RESET_PC+1) mod 2^PC_W, i.e. 0x00, and go to FETCH.
  - imem_req = 0 while in BOOT.
- FETCH:
  - imem_req = !stall. imem_addr = pc_current, combinational.
  - Priority each cycle: branch_taken > halt > stall > imem_ack.
  - branch_taken=1, target < IMEM_DEPTH: pc_current <= branch_target; flush = 1 this cycle; instr_valid = 0; go to BUBBLE with the bubble count loaded to BUBBLE_CYCLES.
  - branch_taken=1, target >= IMEM_DEPTH: addr_err <= 1; go to HALTED; PC unchanged.
  - halt=1 (no branch): go to HALTED; PC unchanged; instr_valid = 0.
  - stall=1: PC holds; imem_req = 0; instr_valid = 0; an imem_ack arriving this cycle is ignored.
  - imem_ack=1 and not stalled: instr_valid = 1 (combinational, same cycle); pc_current <= pc_current+1.
  - Sequential wrap: from IMEM_DEPTH-1 (0x7F) the PC increments to 0x00.
  - imem_ack=0 and not stalled: hold the PC and keep imem_req high. Latency is unbounded; there is no timeout.
- BUBBLE:
  - imem_req = 0, instr_valid = 0.
  - The counter decrements every cycle, stall or not. When it reaches 0, go to FETCH.
  - branch_taken during BUBBLE: accepted with the same rules as in FETCH. The PC is reloaded, flush pulses again and the counter restarts.
  - halt during BUBBLE: go to HALTED.
- HALTED:
  - imem_req = 0, halted = 1, PC frozen. All inputs except rst are ignored.
- Simultaneous branch_taken and halt: the branch wins and halt is dropped. Upstream re-asserts halt if it is still required.
- Arithmetic:
  - All PC arithmetic is PC_W bits, unsigned.
  - The target is absolute; this block adds no offset.
- Registers and outputs:
  - Registered: pc_current, addr_err, state, bubble count.
  - Combinational from state and inputs: imem_req, instr_valid, flush.

Decomposition:
- Shared package (core_pkg):
  - fetch state enum: BOOT, FETCH, BUBBLE, HALTED.
  - PC_W, IMEM_DEPTH, RESET_PC constants.
- One natural sub-module, pc_next_sel:
  - Combinational next-PC mux: hold / +1 with IMEM_DEPTH wrap / branch_target.
  - Range check producing the target-error bit.
- The FSM and the PC register stay in pc_fetch_sequencer.

Test Plan:
1. Reset, then imem_ack held at 1 and no stalls → BOOT for one cycle; then instr_valid every cycle; pc_current runs 0x00, 0x01, 0x02, …; imem_addr equals pc_current each cycle.
2. PC at 0x7F with an ack → next pc_current = 0x00; no addr_err.
3. At pc 0x05, branch_taken=1 with target 0x40, and imem_ack=1 in the same cycle → flush=1 and instr_valid=0 that cycle; then 1 bubble cycle with imem_req=0; then fetch from 0x40.
4. stall high for 3 cycles with imem_ack=1 throughout → pc_current frozen, imem_req=0, no instr_valid. On stall release, fetch resumes at the same address.
5. branch_taken with target 0x90 → addr_err=1 and halted=1 from the next cycle; imem_req stays 0; only rst==0 clears both.
6. Reset (rst=0) asserted mid-bubble, and halt plus branch_taken asserted together → after reset: pc=0xFF, state BOOT, all outputs 0. For the simultaneous case: the redirect is taken, halted stays 0.
